// File: rtl/config_frame_loader.sv
// config_frame_loader: serial configuration frame loader for a TGATE mux.
// Shifts MEM_WIDTH data bits plus one even-parity bit in from ccff_head,
// checks the frame, and only then commits it to mem_out/mem_outb.
// Optional build macro: CFG_ONEHOT_CHECK_EN also rejects staged words with
// more than one bit set. Several TGATEs must never drive one mux output.
module config_frame_loader #(
    parameter int MEM_WIDTH = 4
) (
    input  logic                 prog_clk,
    input  logic                 prog_reset_n,
    input  logic                 cfg_start,
    input  logic                 ccff_head,
    input  logic                 ccff_en,
    output logic                 ccff_tail,
    output logic [0:MEM_WIDTH-1] mem_out,
    output logic [0:MEM_WIDTH-1] mem_outb,
    output logic                 cfg_busy,
    output logic                 cfg_done,
    output logic                 cfg_err
);

    localparam int              CNT_W   = $clog2(MEM_WIDTH + 1);
    localparam logic [CNT_W-1:0] PAR_IDX = CNT_W'(MEM_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CHECK,
        COMMIT,
        ERROR
    } state_e;

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [0:MEM_WIDTH-1]   stage_q;
    logic [0:MEM_WIDTH-1]   stage_d;
    logic [0:MEM_WIDTH-1]   mem_q;
    logic                   par_q;
    logic                   tail_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   err_q;
    logic                   frame_ok_d;

    // Even parity: data bits plus parity bit must XOR to zero.
    function automatic logic parity_ok(input logic [0:MEM_WIDTH-1] w, input logic p);
        return ((^w) ^ p) == 1'b0;
    endfunction

`ifdef CFG_ONEHOT_CHECK_EN
    localparam logic [0:MEM_WIDTH-1] ONE = MEM_WIDTH'(1);

    // Zero or one bit set: clearing the lowest set bit leaves nothing.
    function automatic logic onehot_ok(input logic [0:MEM_WIDTH-1] w);
        return (w & (w - ONE)) == '0;
    endfunction

    // Frame verdict: parity and at-most-one-hot.
    always_comb begin
        frame_ok_d = parity_ok(stage_q, par_q) && onehot_ok(stage_q);
    end
`else
    // Frame verdict: parity only.
    always_comb begin
        frame_ok_d = parity_ok(stage_q, par_q);
    end
`endif

    // New bits enter at the top and walk toward index 0, so the first bit
    // sent ends at index 0. The word is not cleared between frames, so old
    // contents stream out on ccff_tail to chain into the next loader.
    always_comb begin
        stage_d = {stage_q[1:MEM_WIDTH-1], ccff_head};
    end

    // Control FSM with registered status flags, staging and commit register.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stage_q <= '0;
            mem_q   <= '0;
            par_q   <= 1'b0;
            tail_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ERROR: begin
                    if (cfg_start) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (ccff_en) begin
                        if (cnt_q != PAR_IDX) begin
                            stage_q <= stage_d;
                            tail_q  <= stage_q[0];
                            cnt_q   <= cnt_q + 1'b1;
                        end else begin
                            par_q   <= ccff_head;
                            state_q <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (frame_ok_d) begin
                        state_q <= COMMIT;
                        mem_q   <= stage_q;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ERROR;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                COMMIT: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ccff_tail = tail_q;
    assign mem_out   = mem_q;
    assign mem_outb  = ~mem_q;
    assign cfg_busy  = busy_q;
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;

endmodule
